// File: rtl/button_pkg.sv
// Shared definitions for the push-button conditioner.
//   ch_state_t : per-channel press/repeat state
//   cnt_width  : register width able to hold 0..v without wrapping
package button_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        DELAY  = 2'd2,
        REPEAT = 2'd3
    } ch_state_t;

    function automatic int cnt_width(input int v);
        return (v < 1) ? 1 : $clog2(v + 1);
    endfunction

    localparam int DEF_CHANNELS        = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_REPEAT_DELAY    = 25_000_000;
    localparam int DEF_REPEAT_PERIOD   = 5_000_000;

endpackage

// File: rtl/button_channel.sv
// One push-button channel: 2-flop synchroniser, cycle-count debounce
// filter and press / hold-to-repeat pulse FSM.
// Ports:
//   clk        system clock
//   rst        synchronous reset, active low
//   btn_in     raw asynchronous pin
//   repeat_en  auto-repeat enable (synchronous)
//   pulse_out  one-cycle pulse per press and per repeat
//   held       debounced pressed level (1 = pressed)
//
// state  | meaning
// IDLE   | button released, waiting for a debounced press
// PULSE  | pulse_out high for this single cycle
// DELAY  | held after the press pulse, counting up to the first repeat
// REPEAT | held after a repeat pulse, counting up to the next repeat
module button_channel
    import button_pkg::*;
#(
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    input  logic repeat_en,
    output logic pulse_out,
    output logic held
);

    localparam logic RELEASED = (ACTIVE_LOW != 0);
    localparam int   DW       = cnt_width(DEBOUNCE_CYCLES);
    localparam int   MAX_T    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int   TW       = cnt_width(MAX_T);

    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] RD_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RP_LAST = TW'(REPEAT_PERIOD - 1);

    logic            sync1;
    logic            sync2;
    logic            level;
    logic [DW-1:0]   db_cnt;
    ch_state_t       state;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   limit;
    logic            rep;

    // Reset loads the released pin level so a reset never looks like a press.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= RELEASED;
            sync2 <= RELEASED;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    // Normalise so that 1 always means pressed.
    assign level = sync2 ^ RELEASED;

    always_ff @(posedge clk) begin
        if (!rst) begin
            db_cnt <= '0;
            held   <= 1'b0;
        end else if (level != held) begin
            if (db_cnt == DB_LAST) begin
                held   <= level;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    assign limit = (state == REPEAT) ? RP_LAST : RD_LAST;

    // Release is tested before the terminal count so it always wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            timer     <= '0;
            rep       <= 1'b0;
            pulse_out <= 1'b0;
        end else begin
            pulse_out <= 1'b0;
            case (state)
                IDLE: begin
                    rep   <= 1'b0;
                    timer <= '0;
                    if (held) begin
                        state     <= PULSE;
                        pulse_out <= 1'b1;
                    end
                end
                PULSE: begin
                    timer <= '0;
                    if (!held)
                        state <= IDLE;
                    else if (rep)
                        state <= REPEAT;
                    else
                        state <= DELAY;
                end
                DELAY, REPEAT: begin
                    if (!held) begin
                        state <= IDLE;
                        timer <= '0;
                    end else if (!repeat_en) begin
                        timer <= '0;
                    end else if (timer == limit) begin
                        state     <= PULSE;
                        pulse_out <= 1'b1;
                        rep       <= 1'b1;
                        timer     <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                    rep   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/multi_button_shaper.sv
// N-channel push-button conditioner. Each channel is an independent
// button_channel; this level only fans the vector ports out.
// Ports:
//   clk        system clock
//   rst        synchronous reset, active low
//   btn_in     raw asynchronous button pins, one per channel
//   repeat_en  per-channel auto-repeat enable
//   pulse_out  per-channel one-cycle press/repeat pulse
//   held       per-channel debounced pressed level (1 = pressed)
module multi_button_shaper
    import button_pkg::*;
#(
    parameter int CHANNELS        = DEF_CHANNELS,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_in,
    input  logic [CHANNELS-1:0] repeat_en,
    output logic [CHANNELS-1:0] pulse_out,
    output logic [CHANNELS-1:0] held
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        button_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .btn_in    (btn_in[i]),
            .repeat_en (repeat_en[i]),
            .pulse_out (pulse_out[i]),
            .held      (held[i])
        );
    end

endmodule

// File: tb/tb_multi_button_shaper.sv
module tb_multi_button_shaper;

    localparam int CH = 4;
    localparam int AL = 1;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 5;
    localparam bit REL = (AL != 0);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CH-1:0] btn = '1;
    logic [CH-1:0] ren = '0;
    logic [CH-1:0] pulse_out;
    logic [CH-1:0] held;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    multi_button_shaper #(
        .CHANNELS        (CH),
        .ACTIVE_LOW      (AL),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn),
        .repeat_en (ren),
        .pulse_out (pulse_out),
        .held      (held)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model. Debounce: held flips once the last DB synchronised
    // samples all disagree with it. Pulses: one on the edge after held is
    // seen while idle; then, while held, another after a run of RD (first)
    // or RP (later) consecutive enabled edges, the edge leaving a pulse
    // not counting. A disabled edge restarts the run.
    bit m_p1   [CH];
    bit m_p2   [CH];
    bit m_held [CH];
    bit m_pulse[CH];
    bit m_wait [CH];
    bit m_rep  [CH];
    int m_run  [CH];
    bit hist   [CH][DB];

    always @(posedge clk) begin
        cyc++;
        for (int c = 0; c < CH; c++) begin
            if (!rst) begin
                m_p1[c] = REL; m_p2[c] = REL; m_held[c] = 0;
                m_pulse[c] = 0; m_wait[c] = 0; m_rep[c] = 0; m_run[c] = 0;
                for (int k = 0; k < DB; k++) hist[c][k] = 0;
            end else begin
                bit old_h, lvl, alldis;
                int goal;
                old_h = m_held[c];
                goal  = m_rep[c] ? RP : RD;
                if (m_pulse[c]) begin
                    m_pulse[c] = 0;
                    m_run[c]   = 0;
                    m_wait[c]  = old_h;
                    if (!old_h) m_rep[c] = 0;
                end else if (m_wait[c]) begin
                    if (!old_h) begin
                        m_wait[c] = 0; m_rep[c] = 0;
                    end else if (!ren[c]) begin
                        m_run[c] = 0;
                    end else if (m_run[c] + 1 == goal) begin
                        m_pulse[c] = 1; m_rep[c] = 1; m_wait[c] = 0; m_run[c] = 0;
                    end else begin
                        m_run[c]++;
                    end
                end else begin
                    m_rep[c] = 0;
                    if (old_h) m_pulse[c] = 1;
                end
                lvl = (m_p2[c] != REL);
                for (int k = DB - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
                hist[c][0] = lvl;
                alldis = 1;
                for (int k = 0; k < DB; k++) if (hist[c][k] == old_h) alldis = 0;
                if (alldis) m_held[c] = lvl;
                m_p2[c] = m_p1[c];
                m_p1[c] = btn[c];
            end
        end
    end

    logic [CH-1:0] exp_h, exp_p, prev_p = '0;
    int pcnt[CH];
    int ch2_times[$];

    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int c = 0; c < CH; c++) begin
                exp_h[c] = m_held[c];
                exp_p[c] = m_pulse[c];
                if (pulse_out[c] === 1'b1) pcnt[c]++;
            end
            chk("model_held", 32'(held), 32'(exp_h));
            chk("model_pulse", 32'(pulse_out), 32'(exp_p));
            chk("no_back_to_back", 32'(pulse_out & prev_p), 32'd0);
            prev_p = pulse_out;
            if (pulse_out[2] === 1'b1) ch2_times.push_back(cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pulse(input int c, input int maxc, output int at);
        at = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (pulse_out[c] === 1'b1) begin
                at = cyc;
                break;
            end
        end
        chk("wait_pulse", 32'(at >= 0), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, t;
        for (int c = 0; c < CH; c++) pcnt[c] = 0;

        step(3);
        chk("reset_held", 32'(held), 32'd0);
        chk("reset_pulse", 32'(pulse_out), 32'd0);
        rst = 1'b1;
        step(4);

        // Clean press on ch0: held after edge 6, pulse on edge 7 only.
        n = pcnt[0];
        btn[0] = 1'b0;
        step(5);
        chk("clean_held_early", 32'(held[0]), 32'd0);
        step(1);
        chk("clean_held", 32'(held[0]), 32'd1);
        chk("clean_pulse_early", 32'(pulse_out[0]), 32'd0);
        step(1);
        chk("clean_pulse", 32'(pulse_out[0]), 32'd1);
        step(1);
        chk("clean_pulse_width", 32'(pulse_out[0]), 32'd0);
        step(40);
        chk("clean_single", 32'(pcnt[0] - n), 32'd1);
        btn[0] = 1'b1;
        step(DB + 2);
        chk("release_held", 32'(held[0]), 32'd0);
        step(6);

        // Bounce on ch1: 2-cycle runs never pass the filter.
        n = pcnt[1];
        for (int i = 0; i < 14; i++) begin
            btn[1] = ~btn[1];
            step(2);
        end
        btn[1] = 1'b0;
        step(6);
        chk("bounce_quiet", 32'(pcnt[1] - n), 32'd0);
        chk("bounce_pulse_early", 32'(pulse_out[1]), 32'd0);
        step(1);
        chk("bounce_pulse", 32'(pulse_out[1]), 32'd1);
        step(20);
        btn[1] = 1'b1;
        step(12);

        // Auto-repeat on ch2: gaps RD+1 then RP+1.
        ch2_times.delete();
        ren[2] = 1'b1;
        btn[2] = 1'b0;
        step(67);
        btn[2] = 1'b1;
        step(12);
        chk("repeat_count_ok", 32'(ch2_times.size() >= 4), 32'd1);
        if (ch2_times.size() >= 4) begin
            chk("repeat_gap_first", 32'(ch2_times[1] - ch2_times[0]), 32'(RD + 1));
            chk("repeat_gap_2", 32'(ch2_times[2] - ch2_times[1]), 32'(RP + 1));
            chk("repeat_gap_3", 32'(ch2_times[3] - ch2_times[2]), 32'(RP + 1));
        end
        n = pcnt[2];
        step(30);
        chk("repeat_after_release", 32'(pcnt[2] - n), 32'd0);

        // Repeat gating: edges t+15..t+31 see repeat_en low, so the run of
        // RD enabled edges starts at t+32 and fires on edge t+31+RD = t+51.
        btn[2] = 1'b0;
        wait_pulse(2, 20, t);
        step(14);
        ren[2] = 1'b0;
        step(17);
        ren[2] = 1'b1;
        n = pcnt[2];
        step(19);
        chk("gate_quiet", 32'(pcnt[2] - n), 32'd0);
        step(1);
        chk("gate_pulse", 32'(pulse_out[2]), 32'd1);
        chk("gate_time", 32'(cyc - t), 32'd51);
        btn[2] = 1'b1;
        ren[2] = 1'b0;
        step(15);

        // Simultaneous ch0 and ch3.
        btn[0] = 1'b0;
        btn[3] = 1'b0;
        wait_pulse(0, 20, t);
        chk("sim_ch3", 32'(pulse_out[3]), 32'd1);
        chk("sim_ch1_ch2", 32'(pulse_out[2:1]), 32'd0);
        step(1);
        chk("sim_width", 32'({pulse_out[3], pulse_out[0]}), 32'd0);
        btn[3] = 1'b1;
        step(5);

        // Reset while ch0 sits in DELAY.
        rst = 1'b0;
        step(1);
        chk("rst_mid_held", 32'(held), 32'd0);
        chk("rst_mid_pulse", 32'(pulse_out), 32'd0);
        step(1);
        chk("rst_mid_held2", 32'(held), 32'd0);
        rst = 1'b1;
        step(6);
        chk("rst_repress_early", 32'(pulse_out[0]), 32'd0);
        chk("rst_repress_held", 32'(held[0]), 32'd1);
        step(1);
        chk("rst_repress_pulse", 32'(pulse_out[0]), 32'd1);
        btn[0] = 1'b1;
        step(15);

        // Random phase: alternating slow (long holds, repeats) and fast
        // (glitchy) segments, random enables and sporadic resets.
        for (int i = 0; i < 5000; i++) begin
            int thr;
            thr = ((i / 500) % 2 == 0) ? 6 : 70;
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 999) < thr) btn[c] = ~btn[c];
                if ($urandom_range(0, 999) < 15)  ren[c] = ~ren[c];
            end
            rst = ($urandom_range(0, 999) >= 2);
            step(1);
        end
        rst = 1'b1;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
